// File: rtl/mouse_pkg.sv
// Shared types and constants for the mouse click/gesture path.
// Coordinates are 12-bit; the screen is 800x600.
package mouse_pkg;

  localparam int COORD_W = 12;
  localparam int H_RES   = 800;
  localparam int V_RES   = 600;

  localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_RES - 1);
  localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_RES - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRESS1,
    WAIT2,
    PRESS2,
    DRAG
  } state_e;

  function automatic logic [COORD_W-1:0] clamp(input logic [COORD_W-1:0] v,
                                               input logic [COORD_W-1:0] lim);
    return (v > lim) ? lim : v;
  endfunction

  // One extra bit so the unsigned difference can never wrap.
  function automatic logic [COORD_W:0] abs_diff(input logic [COORD_W-1:0] a,
                                                input logic [COORD_W-1:0] b);
    return (a >= b) ? ({1'b0, a} - {1'b0, b}) : ({1'b0, b} - {1'b0, a});
  endfunction

endpackage

// File: rtl/mouse_debounce.sv
// Two-flop synchroniser plus stability counter for one button level.
// rise_o/fall_o flag the cycle in which btn_o is about to toggle.
module mouse_debounce #(
  parameter int CYCLES = 40000
) (
  input  logic clk40MHz,
  input  logic rst,
  input  logic level_i,
  output logic btn_o,
  output logic rise_o,
  output logic fall_o
);

  localparam int                CNT_W    = (CYCLES > 1) ? $clog2(CYCLES) : 1;
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             btn_q;
  logic [CNT_W-1:0] cnt_q;
  logic             toggle;

  assign toggle = (sync2_q != btn_q) && (cnt_q == CNT_LAST);

  // NOTE: every register here uses <= so each flop samples the pre-edge value
  // of its neighbour; blocking assignments would collapse the synchroniser.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      btn_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= level_i;
      sync2_q <= sync1_q;
      if (sync2_q == btn_q) begin
        cnt_q <= '0;
      end else if (toggle) begin
        cnt_q <= '0;
        btn_q <= ~btn_q;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign btn_o  = btn_q;
  assign rise_o = toggle & ~btn_q;
  assign fall_o = toggle &  btn_q;

endmodule

// File: rtl/mouse_click_ctl.sv
// Cursor clamp and left-button gesture classifier (click, double click, drag)
// in the clk40MHz domain; all outputs are registered.
module mouse_click_ctl
  import mouse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 40000,
  parameter int DBL_WINDOW      = 16000000,
  parameter int DRAG_THRESH     = 4
) (
  input  logic               clk40MHz,
  input  logic               rst,
  input  logic               left,
  input  logic [COORD_W-1:0] x_in,
  input  logic [COORD_W-1:0] y_in,
  output logic [COORD_W-1:0] x_out,
  output logic [COORD_W-1:0] y_out,
  output logic               btn,
  output logic               click,
  output logic               dbl_click,
  output logic               drag_active,
  output logic               drag_done,
  output logic [COORD_W-1:0] press_x,
  output logic [COORD_W-1:0] press_y
);

  localparam int                WIN_W    = (DBL_WINDOW > 1) ? $clog2(DBL_WINDOW) : 1;
  localparam logic [WIN_W-1:0]  WIN_LAST = WIN_W'(DBL_WINDOW - 1);
  localparam int                DW       = COORD_W + 1;
  localparam logic [DW-1:0]     THRESH   = DW'(DRAG_THRESH);

  logic               btn_rise;
  logic               btn_fall;
  logic [COORD_W-1:0] x_raw_q, y_raw_q;
  logic [COORD_W-1:0] x_cap_q, y_cap_q;
  logic [COORD_W-1:0] x_out_q, y_out_q;
  logic [COORD_W-1:0] press_x_q, press_y_q;
  logic [WIN_W-1:0]   win_q;
  state_e             state_q;
  logic               click_q, dbl_q, drag_q, done_q;
  logic               moved;

  mouse_debounce #(
    .CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk40MHz(clk40MHz),
    .rst     (rst),
    .level_i (left),
    .btn_o   (btn),
    .rise_o  (btn_rise),
    .fall_o  (btn_fall)
  );

  // A coordinate is accepted only after it reads the same on two samples,
  // which rejects words caught mid-update from the other clock domain.
  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      x_raw_q <= '0;
      y_raw_q <= '0;
      x_cap_q <= '0;
      y_cap_q <= '0;
      x_out_q <= '0;
      y_out_q <= '0;
    end else begin
      x_raw_q <= x_in;
      y_raw_q <= y_in;
      if (x_in == x_raw_q) x_cap_q <= x_in;
      if (y_in == y_raw_q) y_cap_q <= y_in;
      x_out_q <= clamp(x_cap_q, X_MAX);
      y_out_q <= clamp(y_cap_q, Y_MAX);
    end
  end

  assign moved = (abs_diff(x_out_q, press_x_q) > THRESH) ||
                 (abs_diff(y_out_q, press_y_q) > THRESH);

  always_ff @(posedge clk40MHz) begin
    if (rst) begin
      state_q   <= IDLE;
      press_x_q <= '0;
      press_y_q <= '0;
      win_q     <= '0;
      click_q   <= 1'b0;
      dbl_q     <= 1'b0;
      drag_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      click_q <= 1'b0;
      dbl_q   <= 1'b0;
      done_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (btn_rise) begin
            press_x_q <= x_out_q;
            press_y_q <= y_out_q;
            state_q   <= PRESS1;
          end
        end
        PRESS1: begin
          if (moved) begin
            drag_q  <= 1'b1;
            state_q <= DRAG;
          end else if (btn_fall) begin
            click_q <= 1'b1;
            win_q   <= '0;
            state_q <= WAIT2;
          end
        end
        WAIT2: begin
          win_q <= win_q + 1'b1;
          if (btn_rise)              state_q <= PRESS2;
          else if (win_q == WIN_LAST) state_q <= IDLE;
        end
        PRESS2: begin
          if (moved) begin
            drag_q  <= 1'b1;
            state_q <= DRAG;
          end else if (btn_fall) begin
            dbl_q   <= 1'b1;
            state_q <= IDLE;
          end
        end
        DRAG: begin
          if (btn_fall) begin
            drag_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign x_out       = x_out_q;
  assign y_out       = y_out_q;
  assign press_x     = press_x_q;
  assign press_y     = press_y_q;
  assign click       = click_q;
  assign dbl_click   = dbl_q;
  assign drag_active = drag_q;
  assign drag_done   = done_q;

endmodule

// File: doc/mouse_click_ctl.md
Name: mouse_click_ctl

Overview:
Consumes the left-button level and raw 12-bit cursor coordinates produced by the mouse controller, all in the clk40MHz domain.
Clamps coordinates to the 800x600 screen, debounces the button, and classifies gestures as single click, double click or drag.
Registered results feed the UI/game logic and the cursor draw stage.

Parameters:
H_RES, 800, horizontal resolution; x_out clamped to H_RES-1
V_RES, 600, vertical resolution; y_out clamped to V_RES-1
DEBOUNCE_CYCLES, 40000, consecutive stable cycles required to accept a button change (1 ms)
DBL_WINDOW, 16000000, max cycles from first release to second press for a double click (400 ms)
DRAG_THRESH, 4, per-axis movement in pixels that turns a press into a drag; movement must be strictly greater

Ports:
clk40MHz  in  1  pixel-domain clock
rst  in  1  synchronous reset, active-high
left  in  1  raw left-button level; may originate in the 100 MHz domain
x_in  in  12  cursor x from the mouse controller
y_in  in  12  cursor y from the mouse controller
x_out  out  12  clamped, registered cursor x
y_out  out  12  clamped, registered cursor y
btn  out  1  debounced button level
click  out  1  one-cycle pulse: single click completed
dbl_click  out  1  one-cycle pulse: double click completed
drag_active  out  1  high while a drag is in progress
drag_done  out  1  one-cycle pulse at drag release
press_x  out  12  clamped x latched at the gesture's first press
press_y  out  12  clamped y latched at the gesture's first press

Behaviour:
- Reset: all outputs 0; FSM IDLE; debounce counter 0; debounced level 0; window counter 0.
- left passes through a 2-flop synchroniser.
- Coordinate capture: an internal x/y register updates only when x_in/y_in are equal on two consecutive cycles. This filters multi-bit tearing.
- Clamp: x_out = min(x, H_RES-1), y_out = min(y, V_RES-1), registered. Latency is 3 cycles from a stable x_in change to x_out.
- Debounce: the counter increments while the synchronised level differs from btn and clears when they match. When the count reaches DEBOUNCE_CYCLES-1, btn toggles and the counter clears. Press-to-btn latency is 2 + DEBOUNCE_CYCLES cycles.
- Gesture logic uses the debounced rise/fall of btn and the clamped coordinates.
- Deltas are |x_out - press_x| and |y_out - press_y|. Compute them as 13-bit unsigned; no wrap.
- FSM states:
  - IDLE: on btn rise, latch press_x/press_y from x_out/y_out and go to PRESS1.
  - PRESS1: if either delta > DRAG_THRESH, go to DRAG and set drag_active. Otherwise, on btn fall, pulse click, clear the window counter and go to WAIT2.
  - WAIT2: the window counter increments each cycle. On btn rise, go to PRESS2 without relatching press_x/y. When the counter reaches DBL_WINDOW-1, go to IDLE.
  - WAIT2 simultaneous event: a rise in the expiry cycle wins and goes to PRESS2.
  - PRESS2: if either delta > DRAG_THRESH, go to DRAG. On btn fall, pulse dbl_click and go to IDLE.
  - DRAG: on btn fall, clear drag_active, pulse drag_done and go to IDLE.
- A single click always pulses click at the first release. A double click therefore produces click and then dbl_click.
- Pulses are registered and last exactly 1 cycle. At most one of click, dbl_click and drag_done is high in any cycle.
- press_x/press_y hold their value until the next latch in IDLE.
- rst mid-gesture returns to IDLE with no pulse. If the button is held through reset release, it is re-recognised after the debounce time.

Decomposition:
- Package mouse_pkg holds:
  - the FSM state enum (IDLE, PRESS1, WAIT2, PRESS2, DRAG)
  - H_RES, V_RES and coordinate width COORD_W=12.
- Sub-module mouse_debounce (synchroniser + counter, parameter CYCLES) is reused for any future buttons.

Test Plan:
All directed tests use DEBOUNCE_CYCLES=4, DBL_WINDOW=100, DRAG_THRESH=4.
- Clamp: x_in=900, y_in=700 held stable -> x_out=799, y_out=599 after 3 cycles; x_in=100 -> x_out=100.
- Bounce: left toggles every 2 cycles for 20 cycles, then stays high -> btn rises exactly 6 cycles after the final rise, with no earlier change.
- Single click: press at (200,150), release after 20 cycles, no movement -> one click pulse 2+4 cycles after the release; press_x=200, press_y=150; no dbl_click within 100 cycles.
- Double click: two clicks at (300,300) with the second press 50 cycles after the first release -> click, then dbl_click on the second release; a 120-cycle gap instead gives two click pulses.
- Drag: press at (100,100), move to (105,100) -> drag_active=1; move to (400,300) and release -> drag_done pulse, drag_active=0, no click.
- Reset during DRAG: assert rst 1 cycle -> drag_active=0, no drag_done; button still held -> btn rises 6 cycles after rst deasserts, then the FSM enters PRESS1.
